// File: rtl/ddr3_apb_regfile_if.sv
// APB link between the APB bridge (master) and the DDR3 controller register file (slave).
// Signals:
//   sel, enable, write  PSEL / PENABLE / PWRITE from the bridge
//   addr [AW], wdata [DW]  PADDR / PWDATA from the bridge
//   rdata [DW]          PRDATA back to the bridge
//   ready, slverr       PREADY / PSLVERR back to the bridge (slverr valid only with ready)
interface ddr3_apb_regfile_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
);
    logic          sel;
    logic          enable;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;
    logic          slverr;

    modport master (
        output sel, enable, write, addr, wdata,
        input  rdata, ready, slverr
    );

    modport slave (
        input  sel, enable, write, addr, wdata,
        output rdata, ready, slverr
    );
endinterface

// File: rtl/ddr3_apb_regfile.sv
// APB register file for the multi-channel DDR3 controller: MR0-MR3, CTRL/STATUS,
// arbiter mode/priority/weights, and an MRS launch FSM handshaking with the sequencer.
// Ports:
//   aclk, areset_n   clock, async active-low reset
//   apb              APB slave (zero-wait writes, one-wait-state reads, PSLVERR on bad access)
//   mrs_req/sel/data MRS request to the init/command sequencer; mrs_ack accepts it (1-cycle pulse)
//   arb_mode/prio/weight  arbiter configuration, weight ch0 in LSBs
//   irq              registered STATUS.DONE | STATUS.TMO
// DW must be 16. NUM_CH in 1..8, TIMEOUT in 1..65535.
module ddr3_apb_regfile #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DW      = 16,
    parameter int unsigned AW      = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                aclk,
    input  logic                areset_n,
    ddr3_apb_regfile_if.slave   apb,
    output logic                mrs_req,
    output logic [1:0]          mrs_sel,
    output logic [DW-1:0]       mrs_data,
    input  logic                mrs_ack,
    output logic [2:0]          arb_mode,
    output logic [2*NUM_CH-1:0] arb_prio,
    output logic [4*NUM_CH-1:0] arb_weight,
    output logic                irq
);
    localparam int unsigned CNT_W = 16;

    localparam logic [AW-1:0] A_CTRL = AW'(8'h04);
    localparam logic [AW-1:0] A_STAT = AW'(8'h05);
    localparam logic [AW-1:0] A_MODE = AW'(8'hE0);
    localparam logic [AW-1:0] A_PRIO = AW'(8'hE4);
    localparam logic [AW-1:0] A_WGT0 = AW'(8'hC0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Writable bits of each mode register
    function automatic logic [DW-1:0] mr_mask(input logic [1:0] idx);
        case (idx)
            2'd0:    mr_mask = DW'(16'hEE7C);
            2'd1:    mr_mask = DW'(16'hE766);
            2'd2:    mr_mask = DW'(16'hFF38);
            default: mr_mask = DW'(16'h0007);
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mrs_req_q, mrs_req_d;
    logic [1:0]          mrs_sel_q, mrs_sel_d;
    logic [DW-1:0]       mrs_data_q, mrs_data_d;
    logic                done_q, done_d, tmo_q, tmo_d;
    logic [1:0]          last_sel_q, last_sel_d;
    logic                irq_q;

    logic [DW-1:0]       mr_q [4];
    logic                start_q;
    logic [1:0]          ctrl_sel_q;
    logic [2:0]          mode_q;
    logic [2*NUM_CH-1:0] prio_q;
    logic [4*NUM_CH-1:0] wgt_q;
    logic                rd_wait_q;
    logic [DW-1:0]       rdata_q;

    logic          acc_c, wr_c, ready_c, slverr_c, hit_c, busy_c;
    logic          is_mr_c, is_ctrl_c, is_stat_c, is_mode_c, is_prio_c, is_wgt_c;
    logic          start_err_c, launch_c, ctrl_wr_c, stat_wr_c;
    logic          done_set_c, tmo_set_c;
    logic [AW-1:0] woff_c;
    logic [2:0]    widx_c;
    logic [DW-1:0] rdata_c;

    // Address decode and transfer qualification
    assign acc_c     = apb.sel & apb.enable;
    assign wr_c      = acc_c & apb.write;
    assign is_mr_c   = apb.addr < AW'(4);
    assign is_ctrl_c = apb.addr == A_CTRL;
    assign is_stat_c = apb.addr == A_STAT;
    assign is_mode_c = apb.addr == A_MODE;
    assign is_prio_c = apb.addr == A_PRIO;
    assign woff_c    = apb.addr - A_WGT0;
    assign widx_c    = 3'(woff_c >> 2);
    assign is_wgt_c  = (apb.addr >= A_WGT0) && (woff_c < AW'(4 * NUM_CH)) && (apb.addr[1:0] == 2'b00);
    assign hit_c     = is_mr_c | is_ctrl_c | is_stat_c | is_mode_c | is_prio_c | is_wgt_c;
    assign busy_c    = state_q != S_IDLE;

    // A START write while an MRS is in flight is rejected whole, including MR_SEL
    assign start_err_c = apb.write & is_ctrl_c & apb.wdata[0] & busy_c;
    assign launch_c    = wr_c & is_ctrl_c & apb.wdata[0] & ~busy_c;
    assign ctrl_wr_c   = wr_c & is_ctrl_c & ~start_err_c;
    assign stat_wr_c   = wr_c & is_stat_c;

    // Writes complete in the first access cycle, reads after one wait cycle
    assign ready_c  = acc_c & (apb.write | rd_wait_q);
    assign slverr_c = ready_c & (~hit_c | start_err_c);

    assign apb.ready  = ready_c;
    assign apb.slverr = slverr_c;
    assign apb.rdata  = rdata_q;

    // Read data mux; unmapped addresses read zero
    always_comb begin
        rdata_c = '0;
        if (is_mr_c) begin
            rdata_c = mr_q[apb.addr[1:0]];
        end else if (is_ctrl_c) begin
            rdata_c = {ctrl_sel_q, {(DW-3){1'b0}}, start_q};
        end else if (is_stat_c) begin
            rdata_c = DW'({tmo_q, done_q, last_sel_q, busy_c});
        end else if (is_mode_c) begin
            rdata_c = DW'(mode_q);
        end else if (is_prio_c) begin
            rdata_c = DW'(prio_q);
        end else if (is_wgt_c) begin
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (widx_c == 3'(n)) rdata_c = DW'(wgt_q[4*n +: 4]);
            end
        end
    end

    // MRS launch FSM next state, request payload and sticky status
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mrs_req_d  = 1'b0;
        mrs_sel_d  = mrs_sel_q;
        mrs_data_d = mrs_data_q;
        done_set_c = 1'b0;
        tmo_set_c  = 1'b0;
        last_sel_d = last_sel_q;
        case (state_q)
            S_IDLE: begin
                if (launch_c) begin
                    state_d    = S_REQ;
                    cnt_d      = '0;
                    mrs_req_d  = 1'b1;
                    mrs_sel_d  = apb.wdata[DW-1 -: 2];
                    mrs_data_d = mr_q[apb.wdata[DW-1 -: 2]];
                end
            end
            S_REQ: begin
                // ack beats a timeout landing in the same cycle
                if (mrs_ack) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    tmo_set_c = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    mrs_req_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                done_set_c = 1'b1;
                last_sel_d = mrs_sel_q;
            end
            default: state_d = S_IDLE;
        endcase
        // hardware set outranks a W1C in the same cycle
        done_d = done_set_c | (done_q & ~(stat_wr_c & apb.wdata[3]));
        tmo_d  = tmo_set_c  | (tmo_q  & ~(stat_wr_c & apb.wdata[4]));
    end

    // FSM and status registers
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mrs_req_q  <= 1'b0;
            mrs_sel_q  <= '0;
            mrs_data_q <= '0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
            last_sel_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mrs_req_q  <= mrs_req_d;
            mrs_sel_q  <= mrs_sel_d;
            mrs_data_q <= mrs_data_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            last_sel_q <= last_sel_d;
            irq_q      <= done_q | tmo_q;
        end
    end

    // Software-visible configuration registers and APB read path
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < 4; i++) mr_q[i] <= '0;
            start_q    <= 1'b0;
            ctrl_sel_q <= '0;
            mode_q     <= 3'd1;
            prio_q     <= '0;
            wgt_q      <= '0;
            rd_wait_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (wr_c && is_mr_c) mr_q[apb.addr[1:0]] <= apb.wdata & mr_mask(apb.addr[1:0]);
            start_q <= launch_c;
            if (ctrl_wr_c) ctrl_sel_q <= apb.wdata[DW-1 -: 2];
            if (wr_c && is_mode_c) mode_q <= apb.wdata[2:0];
            if (wr_c && is_prio_c) prio_q <= apb.wdata[2*NUM_CH-1:0];
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (wr_c && is_wgt_c && widx_c == 3'(n)) wgt_q[4*n +: 4] <= apb.wdata[3:0];
            end
            // read data is captured in the wait cycle and presented with ready
            rd_wait_q <= acc_c & ~apb.write & ~rd_wait_q;
            if (acc_c && !apb.write && !rd_wait_q) rdata_q <= rdata_c;
        end
    end

    assign mrs_req    = mrs_req_q;
    assign mrs_sel    = mrs_sel_q;
    assign mrs_data   = mrs_data_q;
    assign arb_mode   = mode_q;
    assign arb_prio   = prio_q;
    assign arb_weight = wgt_q;
    assign irq        = irq_q;
endmodule
